// File: rtl/branch_pkg.sv
// Shared constants and the 2-bit saturating counter update for the branch resolve unit.
package branch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == ST) ? ST : cnt + 2'b01;
    else       return (cnt == SNT) ? SNT : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Execute-side request, registered result and fetch lookup bundle of the branch resolve unit.
interface branch_resolve_unit_if #(parameter int XLEN = 32);

  logic [XLEN-1:0] fetch_pc;
  logic            fetch_pred_taken;

  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            pred_taken;

  logic            res_valid;
  logic            res_ready;
  logic            res_taken;
  logic            res_mispredict;
  logic [XLEN-1:0] res_target;
  logic            res_illegal;

  modport master (
    output fetch_pc, in_valid, opcode, funct3, rs1_val, rs2_val, pc, imm, pred_taken, res_ready,
    input  fetch_pred_taken, in_ready, res_valid, res_taken, res_mispredict, res_target, res_illegal
  );

  modport slave (
    input  fetch_pc, in_valid, opcode, funct3, rs1_val, rs2_val, pc, imm, pred_taken, res_ready,
    output fetch_pred_taken, in_ready, res_valid, res_taken, res_mispredict, res_target, res_illegal
  );

endinterface

// File: rtl/branch_bht.sv
// Table of 2-bit saturating counters: one combinational fetch read port, one train write port.
module branch_bht
  import branch_pkg::*;
#(
  parameter  int         BHT_ENTRIES = 64,
  parameter  logic [1:0] CNT_INIT    = WNT,
  localparam int         IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_pred_taken,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] cnt [BHT_ENTRIES];

  // The read port sees the stored value, so a same-index train is visible only next cycle.
  assign rd_pred_taken = cnt[rd_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) cnt[i] <= CNT_INIT;
    end else if (we) begin
      cnt[wr_idx] <= sat_update(cnt[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches (compare, target, mispredict), trains the BHT and serves fetch predictions.
// Optional event counters stat_branches/stat_mispredicts are built when BRANCH_STATS_EN is defined.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CNT_INIT    = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  // Handshake: a request moves when in_valid && in_ready; a result moves when res_valid && res_ready.
  // in_ready = !res_valid || res_ready, so a result can drain and a new one load on the same edge,
  // and a stalled result keeps every res_* field frozen.
  logic            res_valid_q, res_taken_q, res_mispredict_q, res_illegal_q;
  logic [XLEN-1:0] res_target_q;

  logic            accept, is_branch, legal, cond, taken, illegal, mispredict, bht_we;
  logic [XLEN-1:0] target;

  assign bus.in_ready       = !res_valid_q || bus.res_ready;
  assign accept             = bus.in_valid && bus.in_ready;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_taken      = res_taken_q;
  assign bus.res_mispredict = res_mispredict_q;
  assign bus.res_illegal    = res_illegal_q;
  assign bus.res_target     = res_target_q;

  always_comb begin
    is_branch = (bus.opcode == OP_BRANCH);
    legal     = 1'b1;
    cond      = 1'b0;
    case (bus.funct3)
      BEQ:     cond = (bus.rs1_val == bus.rs2_val);
      BNE:     cond = (bus.rs1_val != bus.rs2_val);
      BLT:     cond = ($signed(bus.rs1_val) <  $signed(bus.rs2_val));
      BGE:     cond = ($signed(bus.rs1_val) >= $signed(bus.rs2_val));
      BLTU:    cond = (bus.rs1_val <  bus.rs2_val);
      BGEU:    cond = (bus.rs1_val >= bus.rs2_val);
      default: legal = 1'b0;
    endcase
    taken   = is_branch && legal && cond;
    illegal = is_branch && !legal;
    // Non-branches have taken=0, so this also redirects a false taken-prediction.
    mispredict = !illegal && (taken != bus.pred_taken);
    target     = taken ? (bus.pc + bus.imm) : (bus.pc + XLEN'(4));
    bht_we     = accept && is_branch && legal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      res_illegal_q    <= 1'b0;
      res_target_q     <= '0;
    end else if (accept) begin
      res_valid_q      <= 1'b1;
      res_taken_q      <= taken;
      res_mispredict_q <= mispredict;
      res_illegal_q    <= illegal;
      res_target_q     <= target;
    end else if (bus.res_ready) begin
      res_valid_q      <= 1'b0;
    end
  end

  branch_bht #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .CNT_INIT    (CNT_INIT)
  ) u_bht (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_idx        (bus.fetch_pc[IDX_W+1:2]),
    .rd_pred_taken (bus.fetch_pred_taken),
    .we            (bht_we),
    .wr_idx        (bus.pc[IDX_W+1:2]),
    .wr_taken      (taken)
  );

  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{bus.fetch_pc[XLEN-1:IDX_W+2], bus.fetch_pc[1:0]};

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (accept) begin
      if (is_branch && legal) stat_branches    <= stat_branches + 32'd1;
      if (mispredict)         stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: driver pushes expected results, negedge monitor pops.
module tb_branch_resolve_unit;

  localparam int         XLEN        = 32;
  localparam int         BHT_ENTRIES = 64;
  localparam logic [1:0] CNT_INIT    = 2'b01;
  localparam int         W           = XLEN + 3;
  localparam logic [6:0] OPB         = 7'b1100011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(XLEN)) bus ();

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_resolve_unit #(
    .XLEN(XLEN), .BHT_ENTRIES(BHT_ENTRIES), .CNT_INIT(CNT_INIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int bht_m[BHT_ENTRIES];
  int force_stall = 0;
  bit rand_bp = 0;
  int exp_branches = 0;
  int exp_mispredicts = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] p);
    return int'((p >> 2) % BHT_ENTRIES);
  endfunction

  // Reference: outcome straight from the branch rules, packed as {taken, mispredict, illegal, target}.
  function automatic logic [W-1:0] model(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] p, input logic [31:0] im,
                                         input logic pred, output bit train, output bit mis);
    bit tk, ill;
    int sa, sb;
    longint ua, ub;
    logic [31:0] tgt;
    sa = a; sb = b;
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    tk = 0; ill = 0; train = 0;
    if (op != OPB) begin
      mis = pred;
    end else if (f3 == 3'd2 || f3 == 3'd3) begin
      ill = 1; mis = 0;
    end else begin
      case (f3)
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = (sa < sb);
        3'd5: tk = (sa >= sb);
        3'd6: tk = (ua < ub);
        default: tk = (ua >= ub);
      endcase
      mis = (tk != pred);
      train = 1;
    end
    tgt = tk ? (p + im) : (p + 32'd4);
    return {tk, mis, ill, tgt};
  endfunction

  task automatic check_fetch(input logic [31:0] p);
    bus.fetch_pc = p;
    @(negedge clk);
    chk("fetch_pred", {34'b0, bus.fetch_pred_taken}, {34'b0, bht_m[idx_of(p)] >= 2});
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] p, input logic [31:0] im,
                      input logic pred, output int waits);
    bit acc, train, mis;
    logic [W-1:0] e;
    int idx;
    acc = 0; waits = 0; idx = idx_of(p);
    bus.in_valid = 1; bus.opcode = op; bus.funct3 = f3; bus.rs1_val = a; bus.rs2_val = b;
    bus.pc = p; bus.imm = im; bus.pred_taken = pred; bus.fetch_pc = p;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      chk("fetch_pred_rbw", {34'b0, bus.fetch_pred_taken}, {34'b0, bht_m[idx] >= 2});
      if (bus.in_ready) begin acc = 1; break; end
      waits++;
      @(posedge clk); #1;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end else begin
      e = model(op, f3, a, b, p, im, pred, train, mis);
      exp_q.push_back(e);
      if (train) begin
        exp_branches++;
        if (e[W-1]) bht_m[idx] = (bht_m[idx] == 3) ? 3 : bht_m[idx] + 1;
        else        bht_m[idx] = (bht_m[idx] == 0) ? 0 : bht_m[idx] - 1;
      end
      if (mis) exp_mispredicts++;
    end
    @(posedge clk); #1;
    bus.in_valid = 0;
  endtask

  // Backpressure runs after the driver's #1 so a stall requested on that step takes effect.
  initial begin
    bus.res_ready = 1;
    forever begin
      @(posedge clk); #2;
      if (force_stall > 0) begin bus.res_ready = 0; force_stall--; end
      else if (rand_bp) bus.res_ready = ($urandom_range(0, 3) != 0);
      else bus.res_ready = 1;
    end
  end

  initial begin : monitor
    bit held;
    logic [W-1:0] snap, cur;
    held = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 0;
      end else begin
        cur = {bus.res_taken, bus.res_mispredict, bus.res_illegal, bus.res_target};
        if (held) begin
          chk("hold_outputs", cur, snap);
          chk("hold_valid", {34'b0, bus.res_valid}, {34'b0, 1'b1});
        end
        held = 0;
        if (bus.res_valid && !bus.res_ready) begin
          held = 1; snap = cur;
          chk("in_ready_stall", {34'b0, bus.in_ready}, '0);
        end
        if (bus.res_valid && bus.res_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got %h expected none", cur);
          end else begin
            chk("result", cur, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : main
    int w;
    logic [6:0] op;
    logic [2:0] f3;
    logic [31:0] a, b, p;
    for (int i = 0; i < BHT_ENTRIES; i++) bht_m[i] = int'(CNT_INIT);
    bus.in_valid = 0; bus.opcode = 0; bus.funct3 = 0; bus.rs1_val = 0; bus.rs2_val = 0;
    bus.pc = 0; bus.imm = 0; bus.pred_taken = 0; bus.fetch_pc = 32'h100;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    @(negedge clk);
    chk("rst_valid", {34'b0, bus.res_valid}, '0);
    chk("rst_fields", {bus.res_taken, bus.res_mispredict, bus.res_illegal, bus.res_target}, '0);
    chk("rst_in_ready", {34'b0, bus.in_ready}, {34'b0, 1'b1});
    chk("rst_fetch_pred", {34'b0, bus.fetch_pred_taken}, '0);
    @(posedge clk); #1;

    send(OPB, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, w);
    @(negedge clk);
    chk("tp1_valid", {34'b0, bus.res_valid}, {34'b0, 1'b1});
    chk("tp1_result", {bus.res_taken, bus.res_mispredict, bus.res_illegal, bus.res_target},
        {1'b1, 1'b1, 1'b0, 32'h120});
    @(posedge clk); #1;

    repeat (3) send(OPB, 3'b000, 32'd7, 32'd7, 32'h100, 32'h20, 1'b1, w);
    send(OPB, 3'b000, 32'd7, 32'd8, 32'h100, 32'h20, 1'b1, w);
    check_fetch(32'h100);

    send(OPB, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0, w);
    send(OPB, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0, w);

    send(OPB, 3'b001, 32'd1, 32'd2, 32'h240, 32'h10, 1'b0, w);
    force_stall = 3;
    send(OPB, 3'b101, 32'd3, 32'd2, 32'h244, 32'h10, 1'b1, w);
    chk("stall_waits", W'(w), W'(3));
    send(OPB, 3'b111, 32'd0, 32'd9, 32'h248, 32'h10, 1'b0, w);

    send(OPB, 3'b000, 32'd1, 32'd1, 32'h300, 32'h8, 1'b0, w);
    send(OPB, 3'b010, 32'd1, 32'd1, 32'h300, 32'h8, 1'b1, w);
    send(OPB, 3'b011, 32'd1, 32'd2, 32'h300, 32'h8, 1'b0, w);
    check_fetch(32'h300);
    send(7'b0110011, 3'b000, 32'd1, 32'd1, 32'h300, 32'h8, 1'b1, w);
    check_fetch(32'h300);

    send(OPB, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8, 1'b1, w);
    @(negedge clk);
    chk("wrap_target", {bus.res_taken, bus.res_mispredict, bus.res_illegal, bus.res_target},
        {1'b1, 1'b0, 1'b0, 32'h4});
    @(posedge clk); #1;

    rand_bp = 1;
    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 9) < 8) ? OPB : 7'($urandom);
      if ($urandom_range(0, 9) >= 8 && op == OPB) op = 7'b0010011;
      f3 = 3'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = {a[31], 31'($urandom)};
      p = ($urandom_range(0, 1) == 0) ? {24'h0, 2'($urandom), 4'($urandom), 2'b00}
                                      : ($urandom & 32'hFFFF_FFFC);
      send(op, f3, a, b, p, $urandom, 1'($urandom), w);
      if ($urandom_range(0, 4) == 0) check_fetch({24'h0, 6'($urandom), 2'b00});
    end

    rand_bp = 0;
    repeat (4) @(posedge clk);
    #1;
    force_stall = 6;
    send(OPB, 3'b000, 32'd4, 32'd4, 32'h100, 32'h4, 1'b0, w);
    #1 rst_n = 0;
    exp_q.delete();
    for (int i = 0; i < BHT_ENTRIES; i++) bht_m[i] = int'(CNT_INIT);
    exp_branches = 0; exp_mispredicts = 0;
    #10 force_stall = 0;
    rst_n = 1;
    @(negedge clk);
    chk("midrst_valid", {34'b0, bus.res_valid}, '0);
    chk("midrst_fields", {bus.res_taken, bus.res_mispredict, bus.res_illegal, bus.res_target}, '0);
    @(posedge clk); #1;
    check_fetch(32'h100);
    send(OPB, 3'b000, 32'd4, 32'd4, 32'h100, 32'h4, 1'b0, w);
    check_fetch(32'h100);

    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", W'(exp_q.size()), '0);
`ifdef BRANCH_STATS_EN
    chk("stat_branches", W'(stat_branches), W'(exp_branches));
    chk("stat_mispredicts", W'(stat_mispredicts), W'(exp_mispredicts));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
